// File: rtl/bcp_clause_scanner.sv
// Clause-table BCP scanner: evaluates one stored clause per cycle against an
// assignment snapshot, streams unit implications and stops on the first conflict.
module bcp_clause_scanner #(
  parameter int VAR_NUM    = 8,
  parameter int VAR_W      = 3,
  parameter int CLAUSE_NUM = 16,
  parameter int ADDR_W     = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [VAR_NUM-1:0] wr_mask,
  input  logic [VAR_NUM-1:0] wr_type,
  input  logic               start,
  input  logic [VAR_NUM-1:0] assignment,
  input  logic [VAR_NUM-1:0] free,
  output logic               busy,
  output logic               done,
  output logic               impl_valid,
  input  logic               impl_ready,
  output logic [VAR_W-1:0]   impl_var,
  output logic               impl_value,
  output logic [ADDR_W-1:0]  impl_clause,
  output logic               conflict,
  output logic [ADDR_W-1:0]  conflict_clause,
  output logic [CNT_W-1:0]   unit_count
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CLAUSE_NUM - 1);

  state_t state, state_nxt;

  logic [CLAUSE_NUM-1:0]              tbl_vld;
  logic [CLAUSE_NUM-1:0][VAR_NUM-1:0] tbl_mask;
  logic [CLAUSE_NUM-1:0][VAR_NUM-1:0] tbl_type;

  logic [VAR_NUM-1:0] snap_asg, snap_free;
  logic [ADDR_W-1:0]  idx;

  logic               cur_vld;
  logic [VAR_NUM-1:0] cur_mask, cur_type;
  logic [VAR_NUM-1:0] lit_true, lit_free;
  logic [VAR_W:0]     nfree;
  logic [VAR_W-1:0]   free_pos;
  logic               sat, unit, confl;

  logic take_start, take_confl, take_unit, take_hs, adv;

  assign cur_vld  = tbl_vld[idx];
  assign cur_mask = tbl_mask[idx];
  assign cur_type = tbl_type[idx];

  // Per-variable literal evaluation against the snapshot.
  for (genvar i = 0; i < VAR_NUM; i++) begin : g_lit
    assign lit_true[i] = cur_mask[i] & ~snap_free[i] & (snap_asg[i] == cur_type[i]);
    assign lit_free[i] = cur_mask[i] & snap_free[i];
  end

  always_comb begin
    nfree    = '0;
    free_pos = '0;
    for (int i = 0; i < VAR_NUM; i++) begin
      if (lit_free[i]) begin
        nfree    = nfree + (VAR_W+1)'(1);
        free_pos = VAR_W'(i);
      end
    end
  end

  assign sat   = |lit_true;
  assign unit  = ~sat & (nfree == (VAR_W+1)'(1));
  assign confl = ~sat & (nfree == '0);

  assign busy       = (state == SCAN) || (state == EMIT);
  assign done       = (state == DONE);
  assign impl_valid = (state == EMIT);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    take_confl = 1'b0;
    take_unit  = 1'b0;
    take_hs    = 1'b0;
    adv        = 1'b0;
    case (state)
      IDLE: if (start) begin
        take_start = 1'b1;
        state_nxt  = SCAN;
      end
      SCAN: begin
        // Conflict outranks unit so a falsified clause always aborts.
        if (cur_vld && confl) begin
          take_confl = 1'b1;
          state_nxt  = DONE;
        end else if (cur_vld && unit) begin
          take_unit = 1'b1;
          state_nxt = EMIT;
        end else if (idx == LAST) begin
          state_nxt = DONE;
        end else begin
          adv = 1'b1;
        end
      end
      EMIT: if (impl_ready) begin
        take_hs = 1'b1;
        if (idx == LAST) state_nxt = DONE;
        else begin
          adv       = 1'b1;
          state_nxt = SCAN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tbl_vld         <= '0;
      tbl_mask        <= '0;
      tbl_type        <= '0;
      snap_asg        <= '0;
      snap_free       <= '0;
      idx             <= '0;
      impl_var        <= '0;
      impl_value      <= 1'b0;
      impl_clause     <= '0;
      conflict        <= 1'b0;
      conflict_clause <= '0;
      unit_count      <= '0;
    end else begin
      if (wr_en && !busy) begin
        tbl_vld[wr_addr]  <= 1'b1;
        tbl_mask[wr_addr] <= wr_mask;
        tbl_type[wr_addr] <= wr_type;
      end
      if (take_start) begin
        snap_asg        <= assignment;
        snap_free       <= free;
        idx             <= '0;
        unit_count      <= '0;
        conflict        <= 1'b0;
        conflict_clause <= '0;
      end
      if (take_confl) begin
        conflict        <= 1'b1;
        conflict_clause <= idx;
      end
      if (take_unit) begin
        impl_var    <= free_pos;
        impl_value  <= cur_type[free_pos];
        impl_clause <= idx;
      end
      if (take_hs && (unit_count != '1)) unit_count <= unit_count + CNT_W'(1);
      if (adv) idx <= idx + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_bcp_clause_scanner.sv
// Bench for bcp_clause_scanner: single-clause vector table plus hand-built
// sequences for stalls, mid-scan reset and ignored start/write while busy.
module tb_bcp_clause_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_mask, wr_type;
  logic       start;
  logic [7:0] assignment, free;
  logic       busy, done, impl_valid, impl_ready;
  logic [2:0] impl_var;
  logic       impl_value;
  logic [3:0] impl_clause;
  logic       conflict;
  logic [3:0] conflict_clause;
  logic [7:0] unit_count;

  bcp_clause_scanner dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_mask(wr_mask), .wr_type(wr_type), .start(start),
    .assignment(assignment), .free(free), .busy(busy), .done(done),
    .impl_valid(impl_valid), .impl_ready(impl_ready), .impl_var(impl_var),
    .impl_value(impl_value), .impl_clause(impl_clause), .conflict(conflict),
    .conflict_clause(conflict_clause), .unit_count(unit_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] v;
    logic       val;
    logic [3:0] c;
  } imp_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] mask;
    logic [7:0] typ;
    logic [7:0] asg;
    logic [7:0] fr;
    bit         unit;
    logic [2:0] ivar;
    logic       ival;
    int         done_cyc;
    bit         conf;
    logic [3:0] cc;
    int         cnt;
    string      nm;
  } vec_t;

  imp_t q[$];
  vec_t vecs[7];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] m, input logic [7:0] t);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_mask = m; wr_type = t;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Starts a scan, services the implication stream from the queue and checks
  // the completion state. inj_cyc>0 pulses start plus a write of mask=0 to
  // entry 1 in that cycle while the scan is running.
  task automatic do_scan(input string nm, input int exp_done, input bit exp_conf,
                         input logic [3:0] exp_cc, input int exp_cnt,
                         input int stall_first, input int inj_cyc, input bit with_wr);
    int   cyc;
    bit   got_done;
    int   stall;
    bit   held;
    imp_t hv, e;
    cyc = 1; got_done = 0; stall = stall_first; held = 0; hv = '0;
    @(negedge clk);
    start = 1'b1;
    if (with_wr) wr_en = 1'b1;
    @(negedge clk);
    while (cyc < 200 && !got_done) begin
      if (cyc == inj_cyc) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_mask = 8'h00; wr_type = 8'h00;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (done) begin
        got_done = 1;
        impl_ready = 1'b0;
        check({nm, "_done_cycle"}, 32'(cyc), 32'(exp_done));
        check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
        check({nm, "_conflict"}, 32'(conflict), 32'(exp_conf));
        if (exp_conf) check({nm, "_conflict_clause"}, 32'(conflict_clause), 32'(exp_cc));
        check({nm, "_unit_count"}, 32'(unit_count), 32'(exp_cnt));
      end else if (impl_valid) begin
        if (held) begin
          check({nm, "_stall_stable"}, 32'({impl_var, impl_value, impl_clause}), 32'(hv));
        end
        if (stall > 0) begin
          stall--;
          impl_ready = 1'b0;
          if (!held) begin
            hv = {impl_var, impl_value, impl_clause};
            held = 1;
          end
        end else begin
          impl_ready = 1'b1;
          held = 0;
          if (q.size() == 0) begin
            check({nm, "_unexpected_impl"}, 32'(impl_clause), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            check({nm, "_impl_var"}, 32'(impl_var), 32'(e.v));
            check({nm, "_impl_value"}, 32'(impl_value), 32'(e.val));
            check({nm, "_impl_clause"}, 32'(impl_clause), 32'(e.c));
          end
        end
      end else begin
        impl_ready = 1'b0;
      end
      if (!got_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; wr_en = 1'b0;
    check({nm, "_finished"}, 32'(got_done), 32'd1);
    check({nm, "_missing_impl"}, 32'(q.size()), 32'd0);
    q.delete();
    @(negedge clk);
    check({nm, "_done_one_pulse"}, 32'({done, busy}), 32'd0);
    check({nm, "_count_hold"}, 32'(unit_count), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_type = '0;
    start = 1'b0; assignment = '0; free = '0; impl_ready = 1'b0;

    vecs[0] = '{4'd0,  8'h03, 8'h03, 8'h00, 8'h02, 1, 3'd1, 1'b1, 18, 0, 4'd0,  1, "unit_pos"};
    vecs[1] = '{4'd0,  8'h03, 8'h03, 8'h01, 8'h00, 0, 3'd0, 1'b0, 17, 0, 4'd0,  0, "satisfied"};
    vecs[2] = '{4'd5,  8'h81, 8'h81, 8'h00, 8'h00, 0, 3'd0, 1'b0, 7,  1, 4'd5,  0, "conflict5"};
    vecs[3] = '{4'd3,  8'h00, 8'h00, 8'h00, 8'h00, 0, 3'd0, 1'b0, 5,  1, 4'd3,  0, "empty_mask"};
    vecs[4] = '{4'd15, 8'hF0, 8'h0F, 8'hF0, 8'h40, 1, 3'd6, 1'b0, 18, 0, 4'd0,  1, "unit_last_neg"};
    vecs[5] = '{4'd7,  8'h0C, 8'h04, 8'h00, 8'h0C, 0, 3'd0, 1'b0, 17, 0, 4'd0,  0, "two_free"};
    vecs[6] = '{4'd2,  8'h30, 8'h10, 8'h20, 8'h00, 0, 3'd0, 1'b0, 4,  1, 4'd2,  0, "conflict_mixed"};

    do_reset();
    @(negedge clk);
    check("reset_outputs",
          32'({busy, done, impl_valid, conflict, conflict_clause, unit_count}), 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      wr(vecs[i].addr, vecs[i].mask, vecs[i].typ);
      assignment = vecs[i].asg;
      free       = vecs[i].fr;
      if (vecs[i].unit) q.push_back('{vecs[i].ivar, vecs[i].ival, vecs[i].addr});
      do_scan(vecs[i].nm, vecs[i].done_cyc, vecs[i].conf, vecs[i].cc, vecs[i].cnt, 0, 0, 0);
    end

    // Two units, first one stalled for four cycles.
    do_reset();
    wr(4'd2, 8'h01, 8'h01);
    wr(4'd9, 8'h06, 8'h02);
    assignment = 8'h00; free = 8'h05;
    q.push_back('{3'd0, 1'b1, 4'd2});
    q.push_back('{3'd2, 1'b0, 4'd9});
    do_scan("two_units_stall", 23, 0, 4'd0, 2, 4, 0, 0);

    // Reset while an implication is pending.
    do_reset();
    wr(4'd0, 8'h03, 8'h03);
    assignment = 8'h00; free = 8'h02;
    impl_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20 && !impl_valid; k++) @(negedge clk);
    check("midreset_pending", 32'(impl_valid), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", 32'({busy, impl_valid, done, conflict, unit_count}), 32'd0);
    reset_n = 1'b1;
    do_scan("rescan_empty", 17, 0, 4'd0, 0, 0, 0, 0);

    // start and wr_en while busy are ignored; second scan proves entry 1 unwritten.
    do_reset();
    wr(4'd10, 8'h01, 8'h01);
    assignment = 8'h00; free = 8'h00;
    do_scan("busy_ignore", 12, 1, 4'd10, 0, 0, 3, 0);
    do_scan("busy_ignore_rescan", 12, 1, 4'd10, 0, 0, 0, 0);

    // Write together with start in IDLE: the scan sees the new entry.
    wr_addr = 4'd0; wr_mask = 8'h00; wr_type = 8'h00;
    do_scan("write_with_start", 2, 1, 4'd0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
